// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one bit pair per cycle, LSB first.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             sum_bit, carry_next;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; the latched operand is already inverted.
    assign b_in = sub ? ~b : b;
    assign c_in = sub | cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign accept     = start && (state == IDLE || state == DONE);
    assign sum_bit    = sh_a[0] ^ sh_b[0] ^ carry;
    assign carry_next = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
    assign s_next     = {sum_bit, s[WIDTH-1:1]};

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b1;
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b_in;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            carry <= carry_next;
            s     <= s_next;
            cnt   <= cnt + 1'b1;
            // Flags are only refreshed on the final bit, so they hold between results.
            if (cnt == LAST) begin
                cout <= carry_next;
                ovf  <= carry ^ carry_next;
                zero <= (s_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: arithmetic/latency model plus directed literal vectors.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif
    logic [W-1:0] s;
    logic         cout, ovf, zero, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .s(s), .cout(cout), .ovf(ovf), .zero(zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // {ovf, cout, s} from plain integer arithmetic
    function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
        logic [W:0] full;
        int         sr;
        logic       o;
        full = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        sr   = int'($signed(x)) + int'($signed(y)) + int'(c);
        o    = (sr > (2**(W-1)) - 1) || (sr < -(2**(W-1)));
        return {o, full};
    endfunction

    logic [W-1:0] m_b;
    logic         m_c;
`ifdef SERIAL_ADDER_SUB_EN
    assign m_b = sub ? ~b : b;
    assign m_c = sub | cin;
`else
    assign m_b = b;
    assign m_c = cin;
`endif

    // Model: an operation occupies W busy cycles, then one done cycle.
    int           m_cnt = 0;
    bit           m_done = 1'b0;
    logic [W+1:0] p_res = '0;
    logic [W-1:0] m_s = '0;
    logic         m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_s    <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
            m_zero <= 1'b1;
        end else if (start && m_cnt == 0) begin
            m_cnt  <= W;
            m_done <= 1'b0;
            p_res  <= golden(a, m_b, m_c);
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_s    <= p_res[W-1:0];
                m_cout <= p_res[W];
                m_ovf  <= p_res[W+1];
                m_zero <= (p_res[W-1:0] == '0);
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("mdl_busy", busy, (m_cnt > 0));
            chk("mdl_done", done, m_done);
            chk("mdl_cout", cout, m_cout);
            chk("mdl_ovf", ovf, m_ovf);
            chk("mdl_zero", zero, m_zero);
            if (m_cnt == 0) chk("mdl_s", s, m_s);
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        chk("done_seen", done, 1);
    endtask

    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                          output int lat, output int nb);
        @(negedge clk);
        a = ai; b = bi; cin = ci; start = 1'b1;
        lat = 0;
        nb  = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) nb++;
        end while (!done && lat < 20);
        chk("op_done_seen", done, 1);
    endtask

    task automatic op_chk(input string nm, input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic ci, input logic [W-1:0] es, input logic ec,
                          input logic eo, input logic ez);
        int lat, nb;
        run_op(ai, bi, ci, lat, nb);
        chk({nm, "_lat"}, lat, 5);
        chk({nm, "_busy"}, nb, 4);
        chk({nm, "_s"}, s, es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_ovf"}, ovf, eo);
        chk({nm, "_zero"}, zero, ez);
    endtask

    initial begin
        int n, nd;
        repeat (2) @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        op_chk("zero_op", 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        op_chk("p7_1", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        op_chk("p15_1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        op_chk("p15_15c", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
        op_chk("p5_6", 4'd5, 4'd6, 1'b0, 4'd11, 1'b0, 1'b1, 1'b0);
        op_chk("p8_8", 4'd8, 4'd8, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        op_chk("p2_3c", 4'd2, 4'd3, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        op_chk("s5_3", 4'd5, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        op_chk("s3_5", 4'd3, 4'd5, 1'b0, 4'd14, 1'b0, 1'b0, 1'b0);
        op_chk("s8_1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0);
        op_chk("s4_4", 4'd4, 4'd4, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
        sub = 1'b0;
`endif

        // start held high: restarts every 5 cycles; operand change mid-run is ignored
        @(negedge clk);
        a = 4'd3; b = 4'd4; cin = 1'b0; start = 1'b1;
        repeat (2) @(negedge clk);
        a = 4'd9;
        wait_done(n);
        chk("cont_lat1", n, 3);
        chk("cont_s1", s, 7);
        a = 4'd3;
        wait_done(n);
        chk("cont_period1", n, 5);
        chk("cont_s2", s, 7);
        wait_done(n);
        chk("cont_period2", n, 5);
        chk("cont_s3", s, 7);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // reset during the second RUN cycle
        a = 4'd6; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_s", s, 0);
        chk("mrst_zero", zero, 1);
        chk("mrst_done", done, 0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mrst_no_done", nd, 0);
        rst_n = 1'b1;
        a = 4'd2; b = 4'd3; cin = 1'b0; start = 1'b1;
        nd = 0;
        n  = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 20);
        chk("post_rst_lat", n, 5);
        chk("post_rst_s", s, 5);
        chk("post_rst_zero", zero, 0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..32).
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start, input, 1 bit: request a new operation; sampled only in IDLE or DONE.
REQ-005 Port a, input, WIDTH bits: operand A, captured on an accepted start.
REQ-006 Port b, input, WIDTH bits: operand B, captured on an accepted start.
REQ-007 Port cin, input, 1 bit: carry-in, captured on an accepted start.
REQ-008 Port sub, input, 1 bit: subtract mode, present only with SERIAL_ADDER_SUB_EN.
REQ-009 Port s, output, WIDTH bits: registered sum.
REQ-010 Port cout, output, 1 bit: registered carry-out of the MSB.
REQ-011 Port ovf, output, 1 bit: registered two's-complement overflow, equal to the carry into the MSB XOR cout.
REQ-012 Port zero, output, 1 bit: registered flag, high when s == 0.
REQ-013 Port busy, output, 1 bit: high while in RUN.
REQ-014 Port done, output, 1 bit: one-cycle pulse marking valid results.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, with the following transitions:
- IDLE to RUN on start.
- RUN to DONE after WIDTH bit-cycles.
- DONE to RUN on start.
- DONE to IDLE when start is low.
REQ-016 An accepted start at edge T SHALL do all of the following:
- latch a, b and cin into internal shift registers;
- clear the bit counter;
- set busy from T+1.
REQ-017 In RUN, each cycle SHALL add exactly one bit pair, LSB first, through a 1-bit full-adder cell:
- the sum bit shifts into s from the MSB side;
- the carry is held in a carry flip-flop.
REQ-018 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL count 0..WIDTH-1. The state SHALL leave RUN on the cycle after the count reaches WIDTH-1, with no wrap into a further bit.
REQ-019 Latency from start to results SHALL be fixed:
- busy SHALL be high for exactly WIDTH cycles, T+1..T+WIDTH;
- done SHALL be high only in cycle T+WIDTH+1.
REQ-020 s, cout, ovf and zero SHALL be updated together on the edge that enters DONE. They SHALL then hold until the next DONE entry or reset.
REQ-021 s SHALL be observable shifting during RUN; only values present while done is high are defined as results.
REQ-022 Start asserted during RUN SHALL be ignored: no relatch, no restart, latency unchanged.
REQ-023 Start asserted in the DONE cycle SHALL be accepted. That gives back-to-back operations every WIDTH+1 cycles.
REQ-024 a, b and cin changing after acceptance SHALL NOT affect the current result.
REQ-025 The arithmetic SHALL be modulo 2^WIDTH, with cout carrying the (WIDTH+1)th bit.

Reset
REQ-026 Asserting rst_n low SHALL immediately, in any state including mid-RUN, do all of the following:
- force IDLE;
- clear s, cout, ovf, busy and done to 0;
- set zero to 1;
- clear the counter, the shift registers and the carry flip-flop.
REQ-027 An operation interrupted by reset SHALL NOT produce done.
REQ-028 After rst_n is deasserted, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-029 Macro SERIAL_ADDER_SUB_EN defined: port sub exists and is latched on start. When the latched sub is 1, the block SHALL use inverted b and an initial carry of 1 (cin ignored), so that s = a - b and cout = 1 means no borrow.
REQ-030 Macro SERIAL_ADDER_SUB_EN undefined: port sub and its logic SHALL be absent, and the block SHALL perform a + b + cin only.

Verification (WIDTH=4)
REQ-031 Case a=0, b=0, cin=0, start: done at T+5 with s=0, cout=0, ovf=0, zero=1; busy high for exactly 4 cycles.
REQ-032 Case a=7, b=1, cin=0: s=8, cout=0, ovf=1, zero=0. Case a=15, b=1, cin=0: s=0, cout=1, ovf=0, zero=1. Case a=15, b=15, cin=1: s=15, cout=1.
REQ-033 Case start held high continuously with a=3, b=4: start during busy is ignored, done pulses every 5 cycles with s=7, and changing a to 9 mid-RUN does not alter that result.
REQ-034 Case rst_n pulsed low at the 2nd RUN cycle: immediate IDLE, busy=0, s=0, zero=1, and no done. A following start with a=2, b=3 gives s=5 at T+5.
REQ-035 Case SUB_EN build, a=5, b=3, sub=1: s=2, cout=1. Case a=3, b=5, sub=1: s=14, cout=0. Case a=8, b=1, sub=1: s=7, ovf=1.
